// File: rtl/exit_gate_if.sv
// Exit-side bundle between the spots register, the exit gate and the display path.
// The master drives requests and occupancy; the slave returns release, gate and fee.
interface exit_gate_if #(
    parameter int SPOTS = 4,
    parameter int FEE_W = 8
);
    localparam int SEL_W = (SPOTS > 1) ? $clog2(SPOTS) : 1;

    logic             exit_req;
    logic [SEL_W-1:0] spot_sel;
    logic [SPOTS-1:0] occupied;
    logic [SPOTS-1:0] park_start;
    logic [SPOTS-1:0] spot_release;
    logic             gate_open;
    logic [FEE_W-1:0] fee;
    logic             fee_valid;
    logic             err_empty;
    logic             busy;

    modport master (
        output exit_req, spot_sel, occupied, park_start,
        input  spot_release, gate_open, fee, fee_valid, err_empty, busy
    );

    modport slave (
        input  exit_req, spot_sel, occupied, park_start,
        output spot_release, gate_open, fee, fee_valid, err_empty, busy
    );
endinterface

// File: rtl/exit_gate.sv
// Departure controller: validates an exit request, releases the spot,
// charges a duration-based fee and holds the barrier open for a fixed time.
module exit_gate #(
    parameter int SPOTS            = 4,
    parameter int TICK_DIV         = 16,
    parameter int GATE_OPEN_CYCLES = 8,
    parameter int BASE_FEE         = 1,
    parameter int RATE             = 1,
    parameter int FEE_W            = 8
) (
    input logic        CLK,
    input logic        RST,
    exit_gate_if.slave gate
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (GATE_OPEN_CYCLES > 1) ? $clog2(GATE_OPEN_CYCLES) : 1;
    localparam int XW = FEE_W + 34;
    localparam logic [FEE_W-1:0] DMAX = '1;

    typedef enum logic {
        IDLE,
        OPEN
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [PW-1:0]    pre;
    logic             tick;
    logic [FEE_W-1:0] dur [SPOTS];
    logic [XW-1:0]    fee_full;
    logic [FEE_W-1:0] fee_next;
    logic             sel_hit;
    logic [SPOTS-1:0] sel_onehot;

    assign tick = (pre == PW'(TICK_DIV - 1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pre <= '0;
        end else begin
            pre <= tick ? '0 : pre + PW'(1);
        end
    end

    // Clearing on release keeps a stale duration from leaking into the next car.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < SPOTS; i++) dur[i] <= '0;
        end else begin
            for (int i = 0; i < SPOTS; i++) begin
                if (gate.park_start[i] || gate.spot_release[i]) begin
                    dur[i] <= '0;
                end else if (tick && gate.occupied[i] && dur[i] != DMAX) begin
                    dur[i] <= dur[i] + FEE_W'(1);
                end
            end
        end
    end

    always_comb begin
        fee_full   = XW'(BASE_FEE) + XW'(RATE) * XW'(dur[gate.spot_sel]);
        fee_next   = (fee_full > XW'(DMAX)) ? DMAX : fee_full[FEE_W-1:0];
        sel_hit    = gate.occupied[gate.spot_sel];
        sel_onehot = SPOTS'(1) << gate.spot_sel;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state             <= IDLE;
            cnt               <= '0;
            gate.spot_release <= '0;
            gate.gate_open    <= 1'b0;
            gate.fee          <= '0;
            gate.fee_valid    <= 1'b0;
            gate.err_empty    <= 1'b0;
            gate.busy         <= 1'b0;
        end else begin
            gate.spot_release <= '0;
            gate.err_empty    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (gate.exit_req && sel_hit) begin
                        state             <= OPEN;
                        cnt               <= CW'(GATE_OPEN_CYCLES - 1);
                        gate.spot_release <= sel_onehot;
                        gate.fee          <= fee_next;
                        gate.gate_open    <= 1'b1;
                        gate.fee_valid    <= 1'b1;
                        gate.busy         <= 1'b1;
                    end else if (gate.exit_req) begin
                        gate.err_empty <= 1'b1;
                    end
                end
                OPEN: begin
                    if (cnt == '0) begin
                        state          <= IDLE;
                        gate.gate_open <= 1'b0;
                        gate.fee_valid <= 1'b0;
                        gate.busy      <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exit_gate.sv
// Scenario bench for exit_gate; the bench plays the spots register
// and queues the expected release/fee/error for each request it issues.
module tb_exit_gate;
    localparam int SPOTS = 4;
    localparam int FEE_W = 8;
    localparam int GATE  = 8;

    typedef struct {
        logic [SPOTS-1:0] rel;
        logic [FEE_W-1:0] fee;
        logic             err;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    exit_gate_if #(.SPOTS(SPOTS), .FEE_W(FEE_W)) bus ();

    exit_gate #(
        .SPOTS(SPOTS),
        .TICK_DIV(16),
        .GATE_OPEN_CYCLES(GATE),
        .BASE_FEE(1),
        .RATE(1),
        .FEE_W(FEE_W)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .gate(bus.slave)
    );

    always #5 CLK = ~CLK;

    exp_t             sb[$];
    int               passed = 0;
    int               total = 0;
    logic [FEE_W-1:0] last_fee = '0;

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic park(input logic [SPOTS-1:0] m);
        bus.park_start = m;
        bus.occupied   = bus.occupied | m;
        @(negedge CLK);
        bus.park_start = '0;
    endtask

    task automatic request(input int s);
        bus.spot_sel = 2'(s);
        bus.exit_req = 1'b1;
        @(negedge CLK);
        bus.exit_req = 1'b0;
    endtask

    task automatic wait_out(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            if (bus.spot_release != '0 || bus.err_empty) seen = 1'b1;
            else @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        bus.exit_req   = 1'b0;
        bus.spot_sel   = '0;
        bus.occupied   = '0;
        bus.park_start = '0;
        RST = 1'b0;
        cycles(2);
        total++;
        if (bus.spot_release !== '0) $display("FAIL reset_release: got %b want 0000", bus.spot_release);
        else passed++;
        total++;
        if (bus.gate_open !== 1'b0) $display("FAIL reset_gate_open: got %b want 0", bus.gate_open);
        else passed++;
        total++;
        if (bus.fee !== '0) $display("FAIL reset_fee: got %0d want 0", bus.fee);
        else passed++;
        total++;
        if (bus.fee_valid !== 1'b0) $display("FAIL reset_fee_valid: got %b want 0", bus.fee_valid);
        else passed++;
        total++;
        if (bus.err_empty !== 1'b0) $display("FAIL reset_err_empty: got %b want 0", bus.err_empty);
        else passed++;
        total++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy);
        else passed++;
        RST = 1'b1;
        cycles(5);
        total++;
        if (bus.gate_open !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL idle_after_reset: got gate=%b busy=%b want 0 0", bus.gate_open, bus.busy);
        else passed++;
    endtask

    task automatic test_basic();
        exp_t e;
        bit   seen;
        int   n;
        park(4'b0100);
        cycles(48);
        sb.push_back('{rel: 4'b0100, fee: 8'd4, err: 1'b0});
        request(2);
        wait_out(seen);
        total++;
        if (!seen) $display("FAIL basic_timeout: got no release want release");
        else passed++;
        e = sb.pop_front();
        last_fee = e.fee;
        total++;
        if (bus.spot_release !== e.rel) $display("FAIL basic_release: got %b want %b", bus.spot_release, e.rel);
        else passed++;
        total++;
        if (bus.fee !== e.fee) $display("FAIL basic_fee: got %0d want %0d", bus.fee, e.fee);
        else passed++;
        total++;
        if (bus.gate_open !== 1'b1 || bus.fee_valid !== 1'b1 || bus.busy !== 1'b1)
            $display("FAIL basic_open: got gate=%b valid=%b busy=%b want 1 1 1", bus.gate_open, bus.fee_valid, bus.busy);
        else passed++;
        bus.occupied[2] = 1'b0;
        n = 1;
        @(negedge CLK);
        total++;
        if (bus.spot_release !== '0) $display("FAIL basic_release_width: got %b want 0000", bus.spot_release);
        else passed++;
        while (bus.gate_open && n < 50) begin
            n++;
            @(negedge CLK);
        end
        total++;
        if (n !== GATE) $display("FAIL basic_gate_cycles: got %0d want %0d", n, GATE);
        else passed++;
        total++;
        if (bus.busy !== 1'b0 || bus.fee_valid !== 1'b0)
            $display("FAIL basic_close: got busy=%b valid=%b want 0 0", bus.busy, bus.fee_valid);
        else passed++;
        total++;
        if (bus.fee !== e.fee) $display("FAIL basic_fee_hold: got %0d want %0d", bus.fee, e.fee);
        else passed++;
    endtask

    task automatic test_empty();
        exp_t e;
        bit   seen;
        bus.occupied = '0;
        sb.push_back('{rel: '0, fee: last_fee, err: 1'b1});
        request(1);
        wait_out(seen);
        e = sb.pop_front();
        total++;
        if (bus.err_empty !== e.err) $display("FAIL empty_err: got %b want %b", bus.err_empty, e.err);
        else passed++;
        total++;
        if (bus.spot_release !== e.rel || bus.gate_open !== 1'b0)
            $display("FAIL empty_no_open: got rel=%b gate=%b want %b 0", bus.spot_release, bus.gate_open, e.rel);
        else passed++;
        total++;
        if (bus.fee !== e.fee) $display("FAIL empty_fee: got %0d want %0d", bus.fee, e.fee);
        else passed++;
        @(negedge CLK);
        total++;
        if (bus.err_empty !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL empty_pulse: got err=%b busy=%b want 0 0", bus.err_empty, bus.busy);
        else passed++;
        // Spot parked in the same cycle as the request is not yet eligible.
        sb.push_back('{rel: '0, fee: last_fee, err: 1'b1});
        bus.park_start = 4'b0010;
        bus.spot_sel   = 2'd1;
        bus.exit_req   = 1'b1;
        @(negedge CLK);
        bus.exit_req   = 1'b0;
        bus.park_start = '0;
        bus.occupied   = 4'b0010;
        e = sb.pop_front();
        total++;
        if (bus.err_empty !== e.err || bus.spot_release !== e.rel)
            $display("FAIL same_cycle_park: got err=%b rel=%b want %b %b", bus.err_empty, bus.spot_release, e.err, e.rel);
        else passed++;
        cycles(2);
        bus.occupied = '0;
    endtask

    task automatic test_ignored();
        exp_t e;
        bit   seen;
        int   n;
        int   rels;
        int   errs;
        park(4'b0011);
        cycles(16);
        sb.push_back('{rel: 4'b0001, fee: 8'd2, err: 1'b0});
        request(0);
        wait_out(seen);
        e = sb.pop_front();
        last_fee = e.fee;
        total++;
        if (bus.spot_release !== e.rel || bus.fee !== e.fee)
            $display("FAIL ignored_first: got rel=%b fee=%0d want %b %0d", bus.spot_release, bus.fee, e.rel, e.fee);
        else passed++;
        bus.occupied[0] = 1'b0;
        bus.spot_sel = 2'd1;
        n    = 1;
        rels = 0;
        errs = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge CLK);
            bus.exit_req = (c == 1);
            if (bus.spot_release != '0) rels++;
            if (bus.err_empty) errs++;
            if (bus.gate_open) n++;
        end
        total++;
        if (rels !== 0 || errs !== 0)
            $display("FAIL ignored_second: got releases=%0d errors=%0d want 0 0", rels, errs);
        else passed++;
        total++;
        if (n !== GATE) $display("FAIL ignored_gate_cycles: got %0d want %0d", n, GATE);
        else passed++;
        total++;
        if (bus.busy !== 1'b0 || bus.fee !== e.fee)
            $display("FAIL ignored_after: got busy=%b fee=%0d want 0 %0d", bus.busy, bus.fee, e.fee);
        else passed++;
        bus.occupied = '0;
    endtask

    task automatic test_saturation();
        exp_t e;
        bit   seen;
        park(4'b1001);
        cycles(300 * 16);
        sb.push_back('{rel: 4'b0001, fee: 8'd255, err: 1'b0});
        request(0);
        wait_out(seen);
        e = sb.pop_front();
        total++;
        if (bus.spot_release !== e.rel) $display("FAIL sat_release: got %b want %b", bus.spot_release, e.rel);
        else passed++;
        total++;
        if (bus.fee !== e.fee) $display("FAIL sat_fee: got %0d want %0d", bus.fee, e.fee);
        else passed++;
        bus.occupied[0] = 1'b0;
        cycles(10);
        total++;
        if (bus.busy !== 1'b0) $display("FAIL sat_close: got busy=%b want 0", bus.busy);
        else passed++;
        park(4'b1000);
        cycles(16);
        sb.push_back('{rel: 4'b1000, fee: 8'd2, err: 1'b0});
        request(3);
        wait_out(seen);
        e = sb.pop_front();
        last_fee = e.fee;
        total++;
        if (bus.spot_release !== e.rel || bus.fee !== e.fee)
            $display("FAIL restart_fee: got rel=%b fee=%0d want %b %0d", bus.spot_release, bus.fee, e.rel, e.fee);
        else passed++;
        bus.occupied = '0;
        cycles(10);
    endtask

    task automatic test_async_reset();
        exp_t e;
        bit   seen;
        int   n;
        park(4'b0010);
        cycles(16);
        sb.push_back('{rel: 4'b0010, fee: 8'd2, err: 1'b0});
        request(1);
        wait_out(seen);
        e = sb.pop_front();
        total++;
        if (bus.spot_release !== e.rel || bus.fee !== e.fee)
            $display("FAIL arst_accept: got rel=%b fee=%0d want %b %0d", bus.spot_release, bus.fee, e.rel, e.fee);
        else passed++;
        cycles(2);
        #2;
        RST = 1'b0;
        #1;
        total++;
        if (bus.gate_open !== 1'b0 || bus.fee_valid !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL arst_drop: got gate=%b valid=%b busy=%b want 0 0 0", bus.gate_open, bus.fee_valid, bus.busy);
        else passed++;
        total++;
        if (bus.fee !== '0 || bus.spot_release !== '0)
            $display("FAIL arst_clear: got fee=%0d rel=%b want 0 0000", bus.fee, bus.spot_release);
        else passed++;
        @(negedge CLK);
        RST = 1'b1;
        cycles(2);
        sb.push_back('{rel: 4'b0010, fee: 8'd1, err: 1'b0});
        request(1);
        wait_out(seen);
        total++;
        if (!seen) $display("FAIL arst_timeout: got no release want release");
        else passed++;
        e = sb.pop_front();
        total++;
        if (bus.spot_release !== e.rel || bus.fee !== e.fee || bus.gate_open !== 1'b1)
            $display("FAIL arst_reaccept: got rel=%b fee=%0d gate=%b want %b %0d 1",
                     bus.spot_release, bus.fee, bus.gate_open, e.rel, e.fee);
        else passed++;
        bus.occupied = '0;
        n = 1;
        @(negedge CLK);
        while (bus.gate_open && n < 50) begin
            n++;
            @(negedge CLK);
        end
        total++;
        if (n !== GATE) $display("FAIL arst_gate_cycles: got %0d want %0d", n, GATE);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_ignored();
        test_saturation();
        test_async_reset();
        total++;
        if (sb.size() !== 0) $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end
endmodule
